video_timing_gen: RTL
=====================

# video_timing_gen

Generates the raster timing that drives the HDMI output path: hsync, vsync and blank for the VGA-to-DVI encoder, plus the pixel coordinates the frame-buffer or character fetch logic uses. Coordinates are issued FETCH_LATENCY cycles ahead of the matching sync and blank outputs, so the colour returned by a fixed-latency fetch pipeline lines up with its timing. Sits in the clk_pixel domain between the clock generator's lock output and the encoder inputs.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BP, 48, horizontal back porch, in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BP, 33, vertical back porch, in lines
- SYNC_ACTIVE_HIGH, 0, sync polarity (0 = active-low)
- FETCH_LATENCY, 2, cycles from a fetch coordinate to its aligned sync/blank output; range 1..7
- clk_pixel  in  1  pixel clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- run  in  1  level; 0 holds the raster idle (tie to clk_locked)
- fetch_x  out  10  horizontal counter, early stage
- fetch_y  out  10  vertical counter, early stage
- fetch_active  out  1  early-stage coordinate is inside the visible area
- line_start  out  1  pulse, early stage, h==0
- frame_start  out  1  pulse, early stage, h==0 and v==0
- vga_hsync  out  1  delayed, polarity per SYNC_ACTIVE_HIGH
- vga_vsync  out  1  delayed, polarity per SYNC_ACTIVE_HIGH
- vga_blank  out  1  delayed, 1 = outside the visible area

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default); V_TOTAL by the same rule (525 by default). Both must fit in 10 bits. Unsigned compares only.
- h counts 0..H_TOTAL-1 and wraps to 0. v increments when h wraps, and wraps to 0 after V_TOTAL-1.
- Horizontal regions:
  - active: h < H_ACTIVE
  - hsync asserted: H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
- Vertical regions follow the same pattern with v and the V_ parameters.
- fetch_active = h active AND v active.
- Early stage signals are registered outputs of the counters: fetch_x = h, fetch_y = v, fetch_active, line_start, frame_start.
- A delay line of FETCH_LATENCY stages carries {hsync, vsync, blank}, with blank = ~active. Polarity is applied at the output.
- State machine:
  - IDLE: counters held at 0, early pulses 0, delay line filled with the idle value (blank=1, syncs inactive).
  - IDLE → RUN when run=1.
  - RUN → IDLE on run=0, next cycle. Counters reset to 0 and the delay line is flushed to the idle value in the same edge.
- On re-entering RUN, the first frame starts at (0,0) with frame_start asserted.

## Timing
- Reset values: state IDLE, h=v=0, fetch_x=fetch_y=0, fetch_active=0, line_start=0, frame_start=0, vga_blank=1, vga_hsync=vga_vsync=inactive level (1 when SYNC_ACTIVE_HIGH=0).
- Early outputs are one cycle after the counter update. The first RUN cycle presents (0,0) with frame_start=1.
- vga_* for coordinate (x,y) appear exactly FETCH_LATENCY cycles after fetch_x/fetch_y show (x,y).
- reset has priority over run. Asserting reset mid-frame returns every output to its reset value on the next edge.
- run dropping mid-line: no partial sync is held; the syncs go inactive with the flush.
- Frame period is H_TOTAL*V_TOTAL cycles: 420000 by default.

## Configuration
- VIDEO_TIMING_VBLANK_IRQ_EN defined:
  - Adds output vblank_irq (1 bit) and input irq_ack (1 bit).
  - vblank_irq sets at the early stage when h==0 and v==V_ACTIVE, and stays high until an irq_ack cycle.
  - Set and ack in the same cycle: set wins.
  - Reset value 0; cleared in IDLE.
- Not defined: neither port exists and the IRQ logic is not built.

## Test plan
- Reset held, then run=1: frame_start on the first RUN cycle with fetch_x=0, fetch_y=0. vga_blank=0 two cycles later (FETCH_LATENCY=2). Next frame_start exactly 420000 cycles after the first.
- Over one line: fetch_active high for 640 cycles. vga_hsync low for exactly 96 cycles, beginning 656+2 cycles after line_start.
- Over one frame: vga_vsync low for exactly 2 lines (1600 cycles), beginning at line 490. vga_blank high throughout lines 480..524.
- run dropped at h=300, v=100: next edge fetch_x=fetch_y=0, vga_blank=1, syncs high. run restored: frame_start on the first cycle.
- FETCH_LATENCY=5: every vga_* edge is 5 cycles after the corresponding early-stage change.
- With VIDEO_TIMING_VBLANK_IRQ_EN: vblank_irq rises at v=480, h=0 and clears one cycle after irq_ack. Ack coincident with a set leaves vblank_irq=1.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: bundles the run control, the early fetch-stage coordinates
// and the delayed VGA-style timing outputs of video_timing_gen.
// With VIDEO_TIMING_VBLANK_IRQ_EN defined the bundle also carries vblank_irq and irq_ack.
interface video_timing_gen_if;
  logic       run;
  logic [9:0] fetch_x;
  logic [9:0] fetch_y;
  logic       fetch_active;
  logic       line_start;
  logic       frame_start;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vga_blank;
`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
  logic       irq_ack;
  logic       vblank_irq;

  modport master (
    input  run, irq_ack,
    output fetch_x, fetch_y, fetch_active, line_start, frame_start,
    output vga_hsync, vga_vsync, vga_blank, vblank_irq
  );

  modport slave (
    output run, irq_ack,
    input  fetch_x, fetch_y, fetch_active, line_start, frame_start,
    input  vga_hsync, vga_vsync, vga_blank, vblank_irq
  );
`else
  modport master (
    input  run,
    output fetch_x, fetch_y, fetch_active, line_start, frame_start,
    output vga_hsync, vga_vsync, vga_blank
  );

  modport slave (
    output run,
    input  fetch_x, fetch_y, fetch_active, line_start, frame_start,
    input  vga_hsync, vga_vsync, vga_blank
  );
`endif
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator for the pixel clock domain.
// The h/v counters hold the coordinate presented on the next edge. The early stage
// (fetch_x/y, fetch_active, line/frame_start) shows it one edge later, and
// {hsync, vsync, blank} for the same coordinate reach the vga_* pins FETCH_LATENCY
// edges after that, lining up with a fixed-latency pixel fetch.
// Optional feature macro: VIDEO_TIMING_VBLANK_IRQ_EN adds a sticky vblank_irq with irq_ack.
//
// state | meaning
// IDLE  | raster stopped: counters at 0, early pulses 0, delay line holds the idle value
// RUN   | counters advance every pixel clock, outputs follow the raster
module video_timing_gen #(
  parameter int H_ACTIVE         = 640,
  parameter int H_FP             = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BP             = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FP             = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BP             = 33,
  parameter bit SYNC_ACTIVE_HIGH = 1'b0,
  parameter int FETCH_LATENCY    = 2
) (
  input logic                clk_pixel,
  input logic                reset,
  video_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  // {hsync, vsync, blank} before polarity: syncs inactive, blanked
  localparam logic [2:0] SIG_IDLE = 3'b001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state;
  logic [9:0] h;
  logic [9:0] v;
  logic [9:0] h_next;
  logic [9:0] v_next;
  logic       h_act;
  logic       v_act;
  logic       h_sync;
  logic       v_sync;

  logic [9:0] fetch_x_q;
  logic [9:0] fetch_y_q;
  logic       fetch_active_q;
  logic       line_start_q;
  logic       frame_start_q;
  logic [2:0] sig_e;
  logic [2:0] dly [FETCH_LATENCY];

  // region decode and wrap logic for the coordinate about to be presented
  always_comb begin
    h_act  = (h < H_ACT);
    v_act  = (v < V_ACT);
    h_sync = (h >= HS_BEG) && (h < HS_END);
    v_sync = (v >= VS_BEG) && (v < VS_END);
    h_next = h + 10'd1;
    v_next = v;
    if (h == H_LAST) begin
      h_next = '0;
      v_next = (v == V_LAST) ? '0 : v + 10'd1;
    end
  end

  // run/idle state machine with registered early outputs and the sync/blank delay line;
  // dropping run clears the counters and flushes the whole delay line on one edge
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.run) state <= RUN;
        RUN:  if (!bus.run) state <= IDLE;
      endcase
    end

    if (reset || !bus.run) begin
      h              <= '0;
      v              <= '0;
      fetch_x_q      <= '0;
      fetch_y_q      <= '0;
      fetch_active_q <= 1'b0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      sig_e          <= SIG_IDLE;
      for (int i = 0; i < FETCH_LATENCY; i++) begin
        dly[i] <= SIG_IDLE;
      end
    end else begin
      h              <= h_next;
      v              <= v_next;
      fetch_x_q      <= h;
      fetch_y_q      <= v;
      fetch_active_q <= h_act && v_act;
      line_start_q   <= (h == '0);
      frame_start_q  <= (h == '0) && (v == '0);
      sig_e          <= {h_sync, v_sync, ~(h_act && v_act)};
      dly[0]         <= sig_e;
      for (int i = 1; i < FETCH_LATENCY; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign bus.fetch_x      = fetch_x_q;
  assign bus.fetch_y      = fetch_y_q;
  assign bus.fetch_active = fetch_active_q;
  assign bus.line_start   = line_start_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.vga_hsync    = SYNC_ACTIVE_HIGH ? dly[FETCH_LATENCY-1][2] : ~dly[FETCH_LATENCY-1][2];
  assign bus.vga_vsync    = SYNC_ACTIVE_HIGH ? dly[FETCH_LATENCY-1][1] : ~dly[FETCH_LATENCY-1][1];
  assign bus.vga_blank    = dly[FETCH_LATENCY-1][0];

`ifdef VIDEO_TIMING_VBLANK_IRQ_EN
  logic irq_q;

  // sticky flag set as line V_ACTIVE starts at the early stage; a coincident ack loses to the set
  always_ff @(posedge clk_pixel) begin
    if (reset || !bus.run) begin
      irq_q <= 1'b0;
    end else if ((h == '0) && (v == V_ACT)) begin
      irq_q <= 1'b1;
    end else if (bus.irq_ack) begin
      irq_q <= 1'b0;
    end
  end

  assign bus.vblank_irq = irq_q;
`endif

endmodule
